// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// the latched request record and the alignment error rule.
package lsu_pkg;

  localparam int unsigned LSU_N = 32;
  localparam int unsigned LSU_M = 16;
  localparam int unsigned LSU_A = LSU_M + 2;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // Only the byte offset is kept; the word address lives in the memory-port register.
  typedef struct packed {
    logic             we;
    logic [1:0]       size;
    logic             sgn;
    logic [1:0]       off;
    logic [LSU_N-1:0] wdata;
  } lsu_req_t;

  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    err = 1'b1;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = off[0];
      SIZE_W:  err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel from the execute stage and the word-wide memory port.
interface lsu_req_if;
  import lsu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [LSU_A-1:0] req_addr;
  logic [LSU_N-1:0] req_wdata;
  logic             resp_valid;
  logic [LSU_N-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  import lsu_pkg::*;

  logic [LSU_M-1:0] mem_address;
  logic             mem_wf;
  logic [LSU_N-1:0] mem_w;
  logic [LSU_N-1:0] mem_v;

  modport master (
    output mem_address, mem_wf, mem_w,
    input  mem_v
  );

  modport slave (
    input  mem_address, mem_wf, mem_w,
    output mem_v
  );
endinterface

// File: rtl/lsu_align.sv
// Lane logic: extracts and extends load data from a memory word, and merges
// sub-word store data into a memory word (little-endian lanes).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]       i_offset,
  input  logic [1:0]       i_size,
  input  logic             i_signed,
  input  logic [LSU_N-1:0] i_word,
  input  logic [LSU_N-1:0] i_wdata,
  output logic [LSU_N-1:0] o_rdata,
  output logic [LSU_N-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: pick the addressed lane, then zero- or sign-extend.
  always_comb begin
    w_byte = '0;
    for (int k = 0; k < 4; k++) begin
      if (i_offset == 2'(k)) w_byte = i_word[8*k +: 8];
    end
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    o_rdata = '0;
    case (i_size)
      SIZE_B:  o_rdata = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      SIZE_H:  o_rdata = i_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      SIZE_W:  o_rdata = i_word;
      default: o_rdata = '0;
    endcase
  end

  // Store path: overwrite only the addressed lane(s) of the fetched word.
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SIZE_B: begin
        for (int k = 0; k < 4; k++) begin
          if (i_offset == 2'(k)) o_merged[8*k +: 8] = i_wdata[7:0];
        end
      end
      SIZE_H: begin
        if (i_offset[1]) o_merged[31:16] = i_wdata[15:0];
        else             o_merged[15:0]  = i_wdata[15:0];
      end
      SIZE_W:  o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed requests in, word accesses on the memory port.
// Sub-word stores are read-modify-write; loads return a one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  lsu_state_t       r_state;
  lsu_req_t         r_req;
  logic [LSU_M-1:0] r_mem_address;
  logic [LSU_N-1:0] r_mem_w;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [LSU_N-1:0] r_resp_rdata;

  logic             w_accept;
  logic             w_err;
  logic [LSU_N-1:0] w_rdata;
  logic [LSU_N-1:0] w_merged;

  assign req.req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept      = req.req_valid && req.req_ready;
  assign w_err         = req_is_err(req.req_size, req.req_addr[1:0]);

  lsu_align u_align (
    .i_offset (r_req.off),
    .i_size   (r_req.size),
    .i_signed (r_req.sgn),
    .i_word   (mem.mem_v),
    .i_wdata  (r_req.wdata),
    .o_rdata  (w_rdata),
    .o_merged (w_merged)
  );

  // Reset gates the write strobe and response in the same cycle so an abort never leaks.
  assign mem.mem_address = r_mem_address;
  assign mem.mem_wf      = (r_state == ST_WRITE) && !rst;
  assign mem.mem_w       = r_mem_w;
  assign req.resp_valid  = r_resp_valid && !rst;
  assign req.resp_err    = r_resp_err && !rst;
  assign req.resp_rdata  = r_resp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_req         <= '0;
      r_mem_address <= '0;
      r_mem_w       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req.we    <= req.req_we;
            r_req.size  <= req.req_size;
            r_req.sgn   <= req.req_signed;
            r_req.off   <= req.req_addr[1:0];
            r_req.wdata <= req.req_wdata;
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (req.req_we && (req.req_size == SIZE_W)) begin
              r_state       <= ST_WRITE;
              r_mem_address <= req.req_addr[LSU_A-1:2];
              r_mem_w       <= req.req_wdata;
            end else begin
              r_state       <= ST_READ;
              r_mem_address <= req.req_addr[LSU_A-1:2];
            end
          end
        end
        ST_READ: begin
          r_state <= ST_WAIT;
        end
        // Memory data is valid here, one cycle after the address was sampled.
        ST_WAIT: begin
          if (r_req.we) begin
            r_state <= ST_WRITE;
            r_mem_w <= w_merged;
          end else begin
            r_state       <= ST_RESP;
            r_mem_address <= '0;
            r_resp_valid  <= 1'b1;
            r_resp_rdata  <= w_rdata;
          end
        end
        ST_WRITE: begin
          r_state       <= ST_RESP;
          r_mem_address <= '0;
          r_mem_w       <= '0;
          r_resp_valid  <= 1'b1;
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit sitting directly upstream of the CPU's word-addressed `memory` block. It accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake and converts them into word accesses on the memory port (`address`/`wf`/`w`/`v`). Sub-word stores are performed as read-modify-write. Loads are returned lane-extracted and sign- or zero-extended on a one-cycle response pulse.

## Interface
- `N`, 32, data/word width in bits (fixed at 32 for lane logic).
- `M`, 16, memory word-address width; byte address is `M+2` bits.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed`  in  1  sign-extend loads (ignored for word/store).
- `req_addr`  in  M+2  byte address.
- `req_wdata`  in  N  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  N  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or reserved-size request.
- `mem_address`  out  M  word address to memory.
- `mem_wf`  out  1  memory write enable.
- `mem_w`  out  N  memory write data.
- `mem_v`  in  N  memory read data, valid the cycle after `mem_address` is sampled.

## Operation
- States: IDLE, READ, WAIT, WRITE, RESP.
- `req_ready` = (state == IDLE) && !rst. Accept on `req_valid && req_ready`. Latch addr, size, signed, we, and wdata at accept.
- Error check at accept: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11. Error → RESP with `resp_err`=1, no memory access.
- Word store: IDLE→WRITE→RESP. `mem_w` = wdata.
- Load: IDLE→READ→WAIT→RESP. `mem_v` is captured on the WAIT→RESP edge.
- Byte/half store: IDLE→READ→WAIT→WRITE→RESP. The captured word is merged with wdata and written back.
- RESP→IDLE unconditionally. The response has no backpressure.
- `mem_address` = latched `addr[M+1:2]` in READ/WAIT/WRITE, 0 otherwise. `mem_wf` = (state == WRITE) && !rst. `mem_w` = merged word in WRITE, 0 otherwise.
- Lanes are little-endian: byte k occupies bits `8k+7:8k`, selected by `addr[1:0]`. Half lane is selected by `addr[1]`.
- Load extraction: lane value is zero-extended, or sign-extended from bit 7/15 when `req_signed`=1.
- Store merge replaces only the addressed lane(s) with `wdata[7:0]` or `wdata[15:0]`.
- Reset mid-operation aborts the access. No write is issued on the edge where `rst`=1. No response is produced. The unit is in IDLE after that edge.

## Timing
- Accept edge is k. `resp_valid` is high for exactly the cycle after edge:
  - k for an error;
  - k+1 for a word store;
  - k+2 for a load;
  - k+3 for a sub-word store.
- `mem_wf` is high for exactly one cycle per successful store.
- The next accept is possible in the cycle after RESP. Sustained load throughput is 1 per 4 cycles.
- All outputs are decoded from registered state and latched request, with no combinational path from `req_*` to `mem_*` or `resp_*`. The only exception is `req_ready`, which combines state with the `rst` input.
- Reset values: `req_ready`, `resp_valid`, `resp_err`, `mem_wf` = 0 while `rst`=1. `resp_rdata`, `mem_address`, `mem_w` = 0.

## Structure
- Package `lsu_pkg`:
  - size constants `SIZE_B`=2'b00, `SIZE_H`=2'b01, `SIZE_W`=2'b10;
  - state enum `lsu_state_t`.
- Sub-module `lsu_align`: combinational lane extract/extend for loads and lane merge for stores. Inputs are offset, size, signed, word, and wdata.
- The top level holds the FSM and request/capture registers.

## Test plan
The bench instantiates `memory` behind the unit.
- Reset: hold `rst`=1 for 2 cycles → all outputs 0 and `req_ready`=0. After release, `req_ready`=1.
- Word store 0xcafebabe @0x00004 → `mem_wf` pulses once with `mem_address`=0x0001 and `resp_valid` 2 cycles after accept. Word load @0x00004 → `resp_rdata`=0xcafebabe 3 cycles after accept.
- Top-address word store 0xdeadbeef @0x3fffc → `mem_address`=0xffff. Word load @0x3fffc returns 0xdeadbeef.
- Byte store 0x5a @0x00006 → word becomes 0xca5ababe. Then:
  - signed byte load @0x00007 → 0xffffffca;
  - unsigned byte load @0x00007 → 0x000000ca;
  - signed half load @0x00006 → 0xffffca5a;
  - unsigned half load @0x00004 → 0x0000babe.
- Errors:
  - word load @0x00005 → `resp_err`=1, `resp_rdata`=0, pulse 1 cycle after accept, no `mem_wf`;
  - half store @0x00003 → error;
  - `req_size`=11 → error.
- Assert `rst` during WRITE of a byte store → `mem_wf` stays 0, memory word is unchanged, no `resp_valid`, and `req_ready`=1 after `rst` drops.
